ysyx_23060042_ifu_fetch: RTL and testbench
==========================================

Name: ysyx_23060042_ifu_fetch

Overview:
Instruction fetch stage that sits directly upstream of the decode stage. It owns the architectural PC and issues one instruction-memory request at a time over a valid/ready request channel plus a response channel. It holds each fetched word until decode accepts it, and supports PC redirects from the execute stage (taken branch/jump) and a terminal halt on ebreak.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset; the first fetch address.
INST_W, 32, instruction and PC width; fixed at 32 for RV32.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address, equals current PC
imem_rsp_valid  in  1  response valid, single-cycle pulse
imem_rsp_data  in  32  fetched instruction word
imem_rsp_err  in  1  access fault qualifying the response
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  32  held instruction word
inst_pc  out  32  PC of held instruction
inst_fault  out  1  held instruction came back with an access fault
redirect_valid  in  1  execute requests a PC change
redirect_pc  in  32  redirect target
halt  in  1  ebreak committed; stop fetching
halted  out  1  fetch unit is stopped

Behaviour:
- States: BOOT, REQ, WAIT, HOLD, HALT. Asynchronous reset (rst_n=0) gives state=BOOT, pc=RESET_PC, inst=0, inst_pc=0, inst_fault=0, drop=0. All outputs are 0 while in BOOT.
- BOOT -> REQ unconditionally on the first clock edge after reset release.
- REQ: imem_req_valid=1, imem_req_addr=pc. Handshake (valid&ready) -> WAIT.
- WAIT: wait for imem_rsp_valid.
  - If drop=0: latch inst<=rsp_data, inst_pc<=pc, inst_fault<=rsp_err, then go to HOLD.
  - If drop=1: discard the response, clear drop, go to REQ.
- HOLD: inst_valid = 1 & ~redirect_valid. This is a deliberate combinational path from redirect. On inst_valid&inst_ready: pc<=pc+4 (mod 2^32, so 32'hFFFFFFFC wraps to 0), go to REQ.
- Latency: inst_valid rises on the cycle after imem_rsp_valid. With zero-wait memory (ready=1, response one cycle after accept), the minimum is 3 cycles per instruction: REQ, WAIT, HOLD.
- Redirect has priority over all other events except reset. Target pc <= {redirect_pc[31:2], 2'b00}; the low two bits are forced to zero.
  - In REQ without handshake: pc updates and the state stays REQ. The address changes on the next cycle; the memory contract allows this.
  - In REQ with handshake in the same cycle: the issued request is stale. Set drop=1, go to WAIT.
  - In WAIT: set drop=1. If the response arrives in the same cycle, discard it and go directly to REQ.
  - In HOLD: discard the held instruction regardless of inst_ready, go to REQ. No pc+4 is applied.
- Halt: sampled in REQ, WAIT, HOLD. Priority is below redirect but above normal transitions.
  - In REQ without handshake, or in HOLD: go to HALT.
  - In REQ with handshake, or in WAIT: finish draining the outstanding response, discard it, then go to HALT.
  - HALT is terminal until reset: halted=1, imem_req_valid=0, inst_valid=0.
- At most one outstanding memory request at any time.
- A fault does not stop fetch; inst_fault travels with the instruction.
- imem_rsp_valid outside WAIT is ignored. A bench assertion must flag it.

Test Plan:
- Reset release with RESET_PC=32'h80000000, ready=1, 1-cycle response, inst_ready=1 -> addresses 80000000, 80000004, 80000008 issued every 3 cycles; inst_pc matches each address and inst equals the returned data.
- Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst, inst_pc, inst_valid stay stable; no new request is issued; pc+4 is applied only on the accept cycle.
- Redirect in WAIT to 32'h80000103 -> the in-flight response is discarded (inst_valid stays 0); the next request address is 80000100.
- Redirect in HOLD with inst_ready=1 in the same cycle -> inst_valid=0 that cycle; the next request address is the redirect target, not pc+4.
- imem_rsp_err=1 with data 32'hDEADBEEF -> inst_fault=1 with that word; fetch continues at pc+4 after accept.
- halt in WAIT -> the response is drained and discarded; halted=1 from the next cycle; no further imem_req_valid until rst_n pulses low; after reset, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/ysyx_23060042_ifu_fetch.sv
// Instruction fetch stage: owns the PC and issues one imem request at a time.
// It holds each fetched word until decode takes it, follows execute-stage
// redirects, and stops for good on a committed ebreak.
module ysyx_23060042_ifu_fetch #(
    parameter int unsigned            INST_W   = 32,
    parameter logic [INST_W-1:0]      RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [INST_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] inst_pc,
    output logic              inst_fault,
    input  logic              redirect_valid,
    input  logic [INST_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted
);

    localparam logic [INST_W-1:0] PC_STEP = INST_W'(4);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_e;

    state_e            state_q;
    logic [INST_W-1:0] pc_q;
    logic [INST_W-1:0] inst_q;
    logic [INST_W-1:0] inst_pc_q;
    logic              inst_fault_q;
    logic              drop_q;       // the outstanding response is stale
    logic              halt_pend_q;  // halt seen while a response is in flight

    logic              req_fire;
    logic              accept;
    logic [INST_W-1:0] redirect_tgt;

    // Handshake and redirect target decode; the target is word aligned.
    assign req_fire     = (state_q == S_REQ) && imem_req_ready;
    assign accept       = inst_valid && inst_ready;
    assign redirect_tgt = {redirect_pc[INST_W-1:2], 2'b00};

    // Low target bits are discarded on purpose.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Fetch FSM with PC, held-instruction and drain bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
            drop_q       <= 1'b0;
            halt_pend_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_BOOT: begin
                    state_q <= S_REQ;
                end

                S_REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_tgt;
                        if (req_fire) begin
                            // Request already went out for the old PC.
                            drop_q  <= 1'b1;
                            state_q <= S_WAIT;
                        end
                    end else if (halt) begin
                        if (req_fire) begin
                            halt_pend_q <= 1'b1;
                            state_q     <= S_WAIT;
                        end else begin
                            state_q <= S_HALT;
                        end
                    end else if (req_fire) begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_tgt;
                        if (imem_rsp_valid) begin
                            drop_q  <= 1'b0;
                            state_q <= halt_pend_q ? S_HALT : S_REQ;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        drop_q <= 1'b0;
                        if (halt_pend_q || halt) begin
                            state_q <= S_HALT;
                        end else if (drop_q) begin
                            state_q <= S_REQ;
                        end else begin
                            inst_q       <= imem_rsp_data;
                            inst_pc_q    <= pc_q;
                            inst_fault_q <= imem_rsp_err;
                            state_q      <= S_HOLD;
                        end
                    end else if (halt) begin
                        halt_pend_q <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_tgt;
                        state_q <= S_REQ;
                    end else if (halt) begin
                        state_q <= S_HALT;
                    end else if (accept) begin
                        pc_q    <= pc_q + PC_STEP;
                        state_q <= S_REQ;
                    end
                end

                S_HALT: begin
                    drop_q      <= 1'b0;
                    halt_pend_q <= 1'b0;
                end

                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    // Output decode from the state register; inst_valid is also squashed by a live redirect.
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = (state_q == S_REQ) ? pc_q : '0;
    assign inst_valid     = (state_q == S_HOLD) && !redirect_valid;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_fault     = inst_fault_q;
    assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_ysyx_23060042_ifu_fetch.sv
// Bench for the fetch stage: directed scenarios plus a randomized run,
// checked against a transaction-level memory/PC model.
module tb_ysyx_23060042_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;

    ysyx_23060042_ifu_fetch #(
        .INST_W   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    // Stimulus knobs
    logic        rdy, irdy, redir, halt_in;
    logic [31:0] redir_pc;
    int          lat;

    // Memory / PC reference model
    logic        outst;
    int          cnt;
    logic [31:0] out_addr;
    logic [31:0] exp_pc;
    logic [31:0] ov_addr;

    // What was observed in the last cycle
    logic        last_hs, last_acc, last_iv, last_rv, last_halted, last_fault;
    logic [31:0] last_addr, last_inst, last_ipc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == ov_addr) ? 32'hDEAD_BEEF : {a[15:0], ~a[31:16]};
    endfunction

    function automatic logic errf(input logic [31:0] a);
        return (a == ov_addr) ? 1'b1 : (a[4:2] == 3'b111);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk1 ("rst_req_valid",  imem_req_valid, 1'b0);
        chk32("rst_req_addr",   imem_req_addr,  32'h0);
        chk1 ("rst_inst_valid", inst_valid,     1'b0);
        chk32("rst_inst",       inst,           32'h0);
        chk32("rst_inst_pc",    inst_pc,        32'h0);
        chk1 ("rst_inst_fault", inst_fault,     1'b0);
        chk1 ("rst_halted",     halted,         1'b0);
    endtask

    // One clock cycle: drive inputs, sample and check, advance the model.
    task automatic tick();
        logic rsp, hs, acc;
        rsp = outst && (cnt == 0);
        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memf(out_addr) : $urandom();
        imem_rsp_err   = rsp ? errf(out_addr) : 1'($urandom());
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        halt           = halt_in;
        #1;
        hs  = imem_req_valid && imem_req_ready;
        acc = inst_valid && inst_ready;
        last_hs     = hs;
        last_acc    = acc;
        last_iv     = inst_valid;
        last_rv     = imem_req_valid;
        last_halted = halted;
        last_addr   = imem_req_addr;
        last_inst   = inst;
        last_ipc    = inst_pc;
        last_fault  = inst_fault;
        if (imem_req_valid) chk1("one_outstanding", outst, 1'b0);
        if (rsp) chk1("rsp_outside_wait", imem_req_valid | inst_valid | halted, 1'b0);
        if (hs) chk32("req_addr", imem_req_addr, exp_pc);
        if (acc) begin
            chk32("acc_inst_pc", inst_pc,    exp_pc);
            chk32("acc_inst",    inst,       memf(exp_pc));
            chk1 ("acc_fault",   inst_fault, errf(exp_pc));
            n_acc++;
        end
        @(posedge clk);
        #1;
        if (rsp) outst = 1'b0;
        else if (outst && cnt > 0) cnt--;
        if (hs) begin
            outst    = 1'b1;
            cnt      = lat - 1;
            out_addr = last_addr;
        end
        if (redir) exp_pc = {redir_pc[31:2], 2'b00};
        else if (acc) exp_pc = exp_pc + 32'd4;
    endtask

    task automatic wait_hs(input string tag);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last_hs) break;
        end
        chk1(tag, last_hs, 1'b1);
    endtask

    // Leaves the DUT holding an instruction (decode not ready).
    task automatic wait_hold(input string tag);
        irdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last_iv) break;
        end
        chk1(tag, last_iv, 1'b1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        outst  = 1'b0;
        cnt    = 0;
        exp_pc = RESET_PC;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          hs_t[$];
        logic [31:0] hs_a[$];
        logic [31:0] saved_inst, saved_ipc;

        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        rdy = 1'b1; irdy = 1'b1; redir = 1'b0; halt_in = 1'b0; redir_pc = '0; lat = 1;
        outst = 1'b0; cnt = 0; out_addr = '0; exp_pc = RESET_PC; ov_addr = 32'h1;

        // Reset state and zero-wait streaming
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 0) chk1("boot_no_req", last_rv, 1'b0);
            if (last_hs) begin
                hs_t.push_back(c);
                hs_a.push_back(last_addr);
            end
        end
        chk1("t1_hs_count", hs_t.size() >= 3, 1'b1);
        if (hs_t.size() >= 3) begin
            chk32("t1_first_cycle", 32'(hs_t[0]), 32'd1);
            chk32("t1_addr0", hs_a[0], 32'h8000_0000);
            chk32("t1_addr1", hs_a[1], 32'h8000_0004);
            chk32("t1_addr2", hs_a[2], 32'h8000_0008);
            chk32("t1_period1", 32'(hs_t[1] - hs_t[0]), 32'd3);
            chk32("t1_period2", 32'(hs_t[2] - hs_t[1]), 32'd3);
        end

        // Backpressure in HOLD
        wait_hold("t2_reach_hold");
        saved_inst = last_inst;
        saved_ipc  = last_ipc;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1 ("t2_valid_stable", last_iv,   1'b1);
            chk32("t2_inst_stable",  last_inst, saved_inst);
            chk32("t2_pc_stable",    last_ipc,  saved_ipc);
            chk1 ("t2_no_req",       last_rv,   1'b0);
        end
        irdy = 1'b1;
        tick();
        chk1("t2_accept", last_acc, 1'b1);
        wait_hs("t2_next_req");
        chk32("t2_next_addr", last_addr, saved_ipc + 32'd4);

        // Redirect while waiting for the response
        lat = 2;
        wait_hs("t3_req");
        redir = 1'b1; redir_pc = 32'h8000_0103;
        tick();
        redir = 1'b0;
        chk1("t3_no_inst_redir", last_iv, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_hs) break;
            chk1("t3_discarded", last_iv, 1'b0);
        end
        chk1 ("t3_req_seen", last_hs, 1'b1);
        chk32("t3_redir_addr", last_addr, 32'h8000_0100);

        // Redirect in HOLD while decode is ready
        lat = 1;
        wait_hold("t4_reach_hold");
        irdy = 1'b1; redir = 1'b1; redir_pc = 32'h8000_0200;
        tick();
        redir = 1'b0;
        chk1("t4_squashed", last_iv, 1'b0);
        chk1("t4_no_accept", last_acc, 1'b0);
        wait_hs("t4_req");
        chk32("t4_redir_addr", last_addr, 32'h8000_0200);

        // Access fault travels with the word
        ov_addr = 32'h8000_0200;
        wait_hold("t5_reach_hold");
        chk32("t5_inst",  last_inst,  32'hDEAD_BEEF);
        chk1 ("t5_fault", last_fault, 1'b1);
        chk32("t5_pc",    last_ipc,   32'h8000_0200);
        irdy = 1'b1;
        tick();
        chk1("t5_accept", last_acc, 1'b1);
        wait_hs("t5_req");
        chk32("t5_next_addr", last_addr, 32'h8000_0204);

        // PC wraps past the top of the address space
        wait_hold("t6_reach_hold");
        redir = 1'b1; redir_pc = 32'hFFFF_FFFF;
        tick();
        redir = 1'b0;
        wait_hs("t6_req");
        chk32("t6_aligned_addr", last_addr, 32'hFFFF_FFFC);
        wait_hold("t6_hold");
        chk32("t6_hold_pc", last_ipc, 32'hFFFF_FFFC);
        irdy = 1'b1;
        tick();
        wait_hs("t6_wrap_req");
        chk32("t6_wrap_addr", last_addr, 32'h0000_0000);

        // Randomized traffic against the model
        n_acc = 0;
        for (int i = 0; i < 400; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            lat   = int'($urandom_range(1, 4));
            irdy  = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 11) == 0);
            redir_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom();
            tick();
        end
        redir = 1'b0; rdy = 1'b1; irdy = 1'b1; lat = 1;
        chk1("rand_progress", n_acc > 20, 1'b1);

        // Halt while waiting: drain, then stop for good
        wait_hs("t7_req");
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        chk1("t7_not_yet_halted", last_halted, 1'b0);
        chk1("t7_no_inst", last_iv, 1'b0);
        tick();
        chk1("t7_halted", last_halted, 1'b1);
        chk1("t7_halt_no_inst", last_iv, 1'b0);
        for (int i = 0; i < 20; i++) begin
            rdy = 1'(($urandom_range(0, 1)));
            tick();
            chk1("t7_stay_halted", last_halted, 1'b1);
            chk1("t7_no_req", last_rv, 1'b0);
        end

        // Reset restarts fetch at the reset vector
        rdy = 1'b1;
        apply_reset();
        wait_hs("t8_req");
        chk32("t8_restart_addr", last_addr, RESET_PC);
        chk1("t8_not_halted", last_halted, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
